fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage (PC + instruction memory) and the decode/control stage.
- Buffers fetched {PC, instruction} pairs in a small FIFO so fetch keeps running while decode stalls.
- Discards all buffered entries on a branch-taken flush.
- Presents the head entry with a pre-normalized 11-bit opcode for the instruction decoder.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PC_W, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  PC_W  PC of the fetched instruction.
- in_instr  input  INSTR_W  fetched instruction word.
- flush  input  1  branch taken: discard all entries.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  PC_W  PC of the head entry.
- out_instr  output  INSTR_W  instruction of the head entry.
- out_opcode  output  11  normalized opcode of the head entry.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - write pointer, read pointer and count go to 0;
  - out_valid=0, in_ready=1.
  - Storage contents are don't-care.
  - Reset overrides flush, push and pop.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both take effect on the same edge.
- in_ready = (count < DEPTH), combinational from registered count only; it never depends on out_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (count != 0).
  - out_pc and out_instr are read combinationally from the head slot (first-word fall-through).
- Latency: an entry pushed at edge N into an empty queue is visible on the outputs during cycle N+1. There is no same-cycle bypass.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop: count unchanged; head advances and the new entry is written at the tail.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Occupancy is tracked by count, not by pointer comparison.
- Flush (rst_n=1, flush=1):
  - next state: count=0, read pointer = write pointer;
  - any push or pop in the same cycle is ignored, so the entry presented on in_* that cycle is dropped;
  - out_valid=0 in the cycle after the flush.
- Outputs when out_valid=0: out_pc, out_instr and out_opcode are don't-care, but must not be X after reset. The bench checks them only when out_valid=1.
- Opcode normalization (combinational from out_instr):
  - if out_instr[31:24] = 8'b1011_0100 (CBZ): out_opcode = {3'b000, out_instr[31:24]};
  - otherwise: out_opcode = out_instr[31:21].
- Ordering: entries leave in exactly the order accepted. No duplication or loss except by flush.
- Invariant: 0 <= count <= DEPTH at all times.

Test Plan:
- Reset then single push:
  - Stimulus: hold rst_n=0 for 2 cycles, then push pc=0x0, instr=0x8B020020 (ADD).
  - Required: count=0, in_ready=1, out_valid=0 during reset.
  - Required: one cycle after the push, out_valid=1, out_pc=0x0, out_instr=0x8B020020, out_opcode=11'h458.
- Fill to full:
  - Stimulus: push pcs 0x0, 0x4, 0x8, 0xC with out_ready=0, then present 0x10.
  - Required: count=4, in_ready=0, 0x10 not accepted.
  - Required: then pop 4 with out_ready=1; entries are returned in order 0x0..0xC and count falls to 0.
- Simultaneous push and pop:
  - Stimulus: count=2, in_valid=1 and out_ready=1 for 6 cycles.
  - Required: count stays 2 throughout.
  - Required: pointers wrap past DEPTH-1 with the output PC sequence continuous and no gaps.
- CBZ normalization:
  - Stimulus: push instr=0xB4000040.
  - Required: out_opcode=11'h0B4.
  - Stimulus: push instr=0xF8400020 (LDUR).
  - Required: out_opcode=11'h7C2.
- Flush with concurrent push:
  - Stimulus: count=3; assert flush=1 together with in_valid=1 (pc=0x40).
  - Required: next cycle count=0, out_valid=0, and pc 0x40 is never output.
  - Stimulus: then push 0x44.
  - Required: the next output is 0x44.
- Reset mid-operation:
  - Stimulus: count=2; drop rst_n=0 together with flush=0, in_valid=1, out_ready=1.
  - Required: next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers {PC, instruction} pairs, flushes on
// a taken branch and presents the head entry with a normalized 11-bit opcode.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [10:0]              out_opcode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PC_W-1:0]    pc_mem_r    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  // CBZ keeps its 8-bit major opcode zero-extended; everything else uses the top 11 bits.
  function automatic logic [10:0] normalize_opcode(input logic [INSTR_W-1:0] instr);
    logic [10:0] op;
    if (instr[31:24] == 8'b1011_0100) begin
      op = {3'b000, instr[31:24]};
    end else begin
      op = instr[31:21];
    end
    return op;
  endfunction

  // Handshake qualification and head-slot fall-through read.
  always_comb begin
    in_ready   = (count_r < DEPTH_C);
    out_valid  = (count_r != {CNT_W{1'b0}});
    push_s     = in_valid & in_ready;
    pop_s      = out_valid & out_ready;
    out_pc     = pc_mem_r[rd_ptr_r];
    out_instr  = instr_mem_r[rd_ptr_r];
    out_opcode = normalize_opcode(instr_mem_r[rd_ptr_r]);
    count      = count_r;
  end

  // Queue state: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      // Storage cleared so idle outputs never show X.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {PC_W{1'b0}};
        instr_mem_r[i] <= {INSTR_W{1'b0}};
      end
    end else if (flush) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= in_pc;
        instr_mem_r[wr_ptr_r] <= in_instr;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [10:0] out_opcode;
  logic [2:0]  count;

  int total;
  int bad;

  fetch_decode_queue #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = 64'h0; in_instr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset: count=%0d in_ready=%b out_valid=%b required 0/1/0", count, in_ready, out_valid);
      end
    end
    rst_n = 1'b1;
    total++;
    if ($isunknown({out_pc, out_instr, out_opcode})) begin
      bad++;
      $display("FAIL reset_no_x: pc=%h instr=%h op=%h required no X", out_pc, out_instr, out_opcode);
    end
  endtask

  task automatic test_single_push();
    push(64'h0, 32'h8B02_0020);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h8B02_0020 || out_opcode !== 11'h458) begin
      bad++;
      $display("FAIL single_push: v=%b pc=%h instr=%h op=%h required 1/0/8b020020/458", out_valid, out_pc, out_instr, out_opcode);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop: count=%0d v=%b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      push(64'(4 * i), 32'h8B02_0020);
      total++;
      if (count !== 3'(i + 1)) begin
        bad++;
        $display("FAIL fill_count: count=%0d required %0d", count, i + 1);
      end
    end
    in_valid = 1'b1; in_pc = 64'h10;
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full: count=%0d in_ready=%b required 4/0", count, in_ready);
    end
    tick();
    total++;
    if (count !== 3'd4 || out_pc !== 64'h0) begin
      bad++;
      $display("FAIL full_hold: count=%0d head=%h required 4/0", count, out_pc);
    end
    // Pop while full with push offered: push must be refused.
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL full_pop_no_push: count=%0d required 3", count);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * i)) begin
        bad++;
        $display("FAIL drain_order: v=%b pc=%h required 1/%h", out_valid, out_pc, 4 * i);
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: count=%0d v=%b required 0/0", count, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    push(64'h100, 32'h0);
    push(64'h104, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_pc = 64'h108 + 64'(4 * k);
      total++;
      if (count !== 3'd2 || out_pc !== 64'h100 + 64'(4 * k)) begin
        bad++;
        $display("FAIL b2b: cycle=%0d count=%0d pc=%h required 2/%h", k, count, out_pc, 64'h100 + 64'(4 * k));
      end
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (count !== 3'(2 - k) || out_pc !== 64'h118 + 64'(4 * k)) begin
        bad++;
        $display("FAIL b2b_drain: count=%0d pc=%h required %0d/%h", count, out_pc, 2 - k, 64'h118 + 64'(4 * k));
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL b2b_empty: count=%0d required 0", count);
    end
  endtask

  task automatic test_cbz();
    push(64'h200, 32'hB400_0040);
    total++;
    if (out_valid !== 1'b1 || out_opcode !== 11'h0B4) begin
      bad++;
      $display("FAIL cbz_op: v=%b op=%h required 1/0b4", out_valid, out_opcode);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push(64'h204, 32'hF840_0020);
    total++;
    if (out_valid !== 1'b1 || out_opcode !== 11'h7C2 || out_pc !== 64'h204) begin
      bad++;
      $display("FAIL ldur_op: v=%b op=%h pc=%h required 1/7c2/204", out_valid, out_opcode, out_pc);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_flush();
    push(64'h30, 32'h0);
    push(64'h34, 32'h0);
    push(64'h38, 32'h0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h40;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: count=%0d v=%b required 0/0", count, out_valid);
    end
    tick();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop: count=%0d v=%b required 0/0", count, out_valid);
    end
    push(64'h44, 32'h0);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 64'h44 || count !== 3'd1) begin
      bad++;
      $display("FAIL post_flush: v=%b pc=%h count=%0d required 1/44/1", out_valid, out_pc, count);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    push(64'h50, 32'h0);
    push(64'h54, 32'h0);
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_pc = 64'h58;
    tick();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: count=%0d v=%b in_ready=%b required 0/0/1", count, out_valid, in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_after: count=%0d v=%b required 0/0", count, out_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_push();
    test_fill();
    test_back_to_back();
    test_cbz();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
